// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the loader state encoding, switchbox chain geometry and the word-count helper.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } cfg_state_t;

  localparam int unsigned SB_BITS_PER_WIRE = 8;
  localparam int unsigned SB_WIDTH         = 32;
  localparam int unsigned SB_CHAIN_LEN     = SB_WIDTH * SB_BITS_PER_WIRE;

  // Number of bitstream words needed to cover a chain of chain_len bits.
  function automatic int unsigned cfg_words(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_rb_packer.sv
// Packs serial chain-tail bits into readback words, MSB-first.
// A flushed word shorter than WORD_W is left-aligned and zero-filled.
module cfg_rb_packer
  import cfg_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_bit_en,
  input  logic                           i_bit,
  input  logic                           i_flush,
  input  logic [$clog2(WORD_W+1)-1:0]    i_nbits,
  output logic [WORD_W-1:0]              o_data,
  output logic                           o_valid
);

  localparam int unsigned NB_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic [WORD_W-1:0] w_acc_nxt;
  logic [NB_W-1:0]   w_pad;

  assign w_acc_nxt = {r_acc[WORD_W-2:0], i_bit};
  assign w_pad     = NB_W'(WORD_W) - i_nbits;

  // Older bits above the current word are pushed out by the alignment shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_bit_en && i_flush;
      if (i_bit_en) begin
        r_acc <= w_acc_nxt;
      end
      if (i_bit_en && i_flush) begin
        r_data <= w_acc_nxt << w_pad;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration-chain master: serializes bitstream words MSB-first into a
// fabric config shift chain and packs the bits shifted out of the tail.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = SB_CHAIN_LEN,
  parameter int unsigned WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_data_out,
  output logic              cfg_shift_en,
  output logic              cfg_mode,
  input  logic              cfg_data_in,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N_WORDS   = cfg_words(CHAIN_LEN, WORD_W);
  localparam int unsigned LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W      = $clog2(WORD_W + 1);

  cfg_state_t        r_state;
  cfg_state_t        w_next;
  logic [WORD_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WB_W-1:0]   r_word_bits;
  logic [WB_W-1:0]   r_wcnt;
  logic              w_last_shift;
  logic              w_last_word;
  logic              w_flush;

  assign w_last_shift = (r_state == ST_SHIFT) && (r_wcnt == r_word_bits - WB_W'(1));
  assign w_last_word  = (32'(r_bit_cnt) + WORD_W) > CHAIN_LEN;
  assign w_flush      = w_last_shift && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start && !abort) w_next = ST_FETCH;
      ST_FETCH: begin
        if (abort)           w_next = ST_IDLE;
        else if (word_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) w_next = ST_IDLE;
        else if (w_last_shift)
          w_next = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1)) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    word_ready   = 1'b0;
    cfg_mode     = 1'b0;
    busy         = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_data_out = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        word_ready = 1'b1;
        cfg_mode   = 1'b1;
        busy       = 1'b1;
      end
      ST_SHIFT: begin
        cfg_shift_en = 1'b1;
        cfg_mode     = 1'b1;
        busy         = 1'b1;
        cfg_data_out = r_shreg[WORD_W-1];
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Only the final word can be short; its low bits never reach the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_word_bits <= '0;
      r_wcnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) r_bit_cnt <= '0;
        end
        ST_FETCH: begin
          if (word_valid && !abort) begin
            r_shreg     <= word_data;
            r_word_bits <= w_last_word ? WB_W'(LAST_BITS) : WB_W'(WORD_W);
            r_wcnt      <= '0;
          end
        end
        ST_SHIFT: begin
          r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          r_wcnt    <= r_wcnt + WB_W'(1);
        end
        default: ;
      endcase
    end
  end

  cfg_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .clk      (clk),
    .rst      (rst),
    .i_bit_en (cfg_shift_en),
    .i_bit    (cfg_data_in),
    .i_flush  (w_flush),
    .i_nbits  (r_word_bits),
    .o_data   (rb_data),
    .o_valid  (rb_valid)
  );

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: an 8-bit and a 6-bit chain model, both fed 4-bit words.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, start6, abort, word_valid;
  logic [3:0] word_data;

  logic       r8, d8, se8, m8, rbv8, b8, dn8, ci8;
  logic [3:0] rb8;
  logic       r6, d6, se6, m6, rbv6, b6, dn6, ci6;
  logic [3:0] rb6;

  cfg_chain_loader #(.CHAIN_LEN(8), .WORD_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(r8),
    .cfg_data_out(d8), .cfg_shift_en(se8), .cfg_mode(m8), .cfg_data_in(ci8),
    .rb_data(rb8), .rb_valid(rbv8), .busy(b8), .done(dn8)
  );

  cfg_chain_loader #(.CHAIN_LEN(6), .WORD_W(4)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(r6),
    .cfg_data_out(d6), .cfg_shift_en(se6), .cfg_mode(m6), .cfg_data_in(ci6),
    .rb_data(rb6), .rb_valid(rbv6), .busy(b6), .done(dn6)
  );

  // Chain models: left-shifting registers, tail is the MSB.
  logic [7:0] chain8, init8;
  logic [5:0] chain6, init6;
  logic       ld8, ld6;
  always @(posedge clk) begin
    if (ld8)      chain8 <= init8;
    else if (se8) chain8 <= {chain8[6:0], d8};
    if (ld6)      chain6 <= init6;
    else if (se6) chain6 <= {chain6[4:0], d6};
  end
  assign ci8 = chain8[7];
  assign ci6 = chain6[5];

  int         cur_sel;
  logic       o_ready, o_se, o_mode, o_rbv, o_busy, o_done;
  logic [3:0] o_rb;
  assign o_ready = (cur_sel != 0) ? r6   : r8;
  assign o_se    = (cur_sel != 0) ? se6  : se8;
  assign o_mode  = (cur_sel != 0) ? m6   : m8;
  assign o_rbv   = (cur_sel != 0) ? rbv6 : rbv8;
  assign o_busy  = (cur_sel != 0) ? b6   : b8;
  assign o_done  = (cur_sel != 0) ? dn6  : dn8;
  assign o_rb    = (cur_sel != 0) ? rb6  : rb8;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] init;
    logic [3:0] w0;
    logic [3:0] w1;
    int         gap;
    bit         poke;
    logic [7:0] exp_chain;
    logic [3:0] exp_rb0;
    logic [3:0] exp_rb1;
    int         exp_done;
    int         exp_shifts;
  } vec_t;

  vec_t vecs[7];

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) start6 = v;
    else          start8 = v;
  endtask

  // Runs one full two-word load and checks chain, readback, timing and mode.
  task automatic run_load(input string tag, input vec_t v, input bit do_init);
    int edges, shifts, nrb, merr, wi, gapc, done_at;
    logic [3:0] rbw [2];
    logic [7:0] fin;
    edges = 0; shifts = 0; nrb = 0; merr = 0; wi = 0; gapc = 0; done_at = -1;
    rbw[0] = '0; rbw[1] = '0;
    cur_sel = v.sel;
    @(negedge clk);
    if (do_init) begin
      if (v.sel != 0) begin init6 = v.init[5:0]; ld6 = 1'b1; end
      else            begin init8 = v.init;      ld8 = 1'b1; end
    end
    @(posedge clk);
    @(negedge clk);
    ld8 = 1'b0; ld6 = 1'b0;
    set_start(v.sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(v.sel, 1'b0);
    while (done_at < 0 && edges < 200) begin
      if (o_se) shifts++;
      if (o_rbv) begin
        if (nrb < 2) rbw[nrb] = o_rb;
        nrb++;
      end
      if (o_busy && !o_mode) merr++;
      if (o_ready && o_se) merr++;
      if (o_done) begin
        done_at = edges;
        if (o_mode || o_busy) merr++;
      end
      set_start(v.sel, v.poke && o_se);
      if (o_ready && wi < 2) begin
        if (wi == 1 && gapc < v.gap) begin
          word_valid = 1'b0;
          gapc++;
        end else begin
          word_valid = 1'b1;
          word_data  = (wi == 0) ? v.w0 : v.w1;
          wi++;
        end
      end else begin
        word_valid = 1'b0;
      end
      if (done_at < 0) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    word_valid = 1'b0;
    set_start(v.sel, 1'b0);
    fin = (v.sel != 0) ? {2'b00, chain6} : chain8;
    chk($sformatf("%s done_edges", tag), done_at, v.exp_done);
    chk($sformatf("%s chain", tag), 32'(fin), 32'(v.exp_chain));
    chk($sformatf("%s shifts", tag), shifts, v.exp_shifts);
    chk($sformatf("%s rb_count", tag), nrb, 2);
    chk($sformatf("%s rb0", tag), 32'(rbw[0]), 32'(v.exp_rb0));
    chk($sformatf("%s rb1", tag), 32'(rbw[1]), 32'(v.exp_rb1));
    chk($sformatf("%s mode_errs", tag), merr, 0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s idle_after_done", tag), {30'd0, o_done, o_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int ev;
    vec_t va;
    //           sel init   w0    w1    gap poke chain  rb0   rb1   done shifts
    vecs[0] = '{0, 8'hFF, 4'hA, 4'h5, 0, 1'b0, 8'hA5, 4'hF, 4'hF, 10, 8};
    vecs[1] = '{1, 8'h15, 4'hB, 4'h8, 0, 1'b0, 8'h2E, 4'h5, 4'h4,  8, 6};
    vecs[2] = '{0, 8'hFF, 4'hA, 4'h5, 5, 1'b0, 8'hA5, 4'hF, 4'hF, 15, 8};
    vecs[3] = '{0, 8'h00, 4'h3, 4'hC, 0, 1'b0, 8'h3C, 4'h0, 4'h0, 10, 8};
    vecs[4] = '{0, 8'h5A, 4'hF, 4'h0, 0, 1'b0, 8'hF0, 4'h5, 4'hA, 10, 8};
    vecs[5] = '{0, 8'hC3, 4'h6, 4'h9, 0, 1'b1, 8'h69, 4'hC, 4'h3, 10, 8};
    vecs[6] = '{1, 8'h3F, 4'h0, 4'hF, 0, 1'b0, 8'h03, 4'hF, 4'hC,  8, 6};

    rst = 1'b1; start8 = 1'b0; start6 = 1'b0; abort = 1'b0;
    word_valid = 1'b0; word_data = '0; ld8 = 1'b0; ld6 = 1'b0;
    init8 = '0; init6 = '0; cur_sel = 0;
    #12;
    chk("reset_ctrl8", {25'd0, r8, d8, se8, m8, rbv8, b8, dn8}, 32'd0);
    chk("reset_rb8", 32'(rb8), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_load($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Abort after three shift edges of the first word, then restart.
    cur_sel = 0;
    @(negedge clk); init8 = 8'hFF; ld8 = 1'b1;
    @(posedge clk); @(negedge clk); ld8 = 1'b0;
    start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0; word_valid = 1'b1; word_data = 4'hA;
    @(posedge clk); @(negedge clk);
    word_valid = 1'b0;
    ev = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (rbv8 || dn8) ev++;
    end
    chk("abort_pre_shifting", 32'(se8), 32'd1);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_mode", {30'd0, b8, m8}, 32'd0);
    chk("abort_chain", 32'(chain8), 32'hFA);
    for (int k = 0; k < 5; k++) begin
      if (rbv8 || dn8 || r8 || se8) ev++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_events", ev, 0);
    va = vecs[0];
    va.exp_rb1 = 4'hA;
    run_load("restart", va, 1'b0);

    // Asynchronous reset between edges during SHIFT.
    cur_sel = 0;
    @(negedge clk); init8 = 8'hFF; ld8 = 1'b1;
    @(posedge clk); @(negedge clk); ld8 = 1'b0;
    start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0; word_valid = 1'b1; word_data = 4'hA;
    @(posedge clk); @(negedge clk);
    word_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("rst_pre_shift", {30'd0, se8, d8}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", {25'd0, r8, d8, se8, m8, rbv8, b8, dn8}, 32'd0);
    chk("rst_async_rb", 32'(rb8), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_idle_after", {29'd0, b8, r8, se8}, 32'd0);
    run_load("post_rst", vecs[0], 1'b1);

    // start and abort together in IDLE.
    start8 = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("start_abort_idle", {30'd0, b8, r8}, 32'd0);
    start8 = 1'b0; abort = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("start_abort_stays", {30'd0, b8, m8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Configuration-chain master that drives the serial config ports of switchbox/tile shift-register chains. It accepts bitstream words over a valid/ready handshake and serializes them MSB-first into the chain head. While it loads, it captures the bits shifted out of the chain tail and packs them into readback words. It sits between the bitstream source (host interface or ROM reader) and the head of a fabric configuration chain.

## Interface
- `CHAIN_LEN`, default 256: total chain length in bits (one 32-wide switchbox = 32*4*2).
- `WORD_W`, default 32: bitstream and readback word width.
- `N_WORDS`: derived, `ceil(CHAIN_LEN/WORD_W)`, not overridable.

Ports:
- `clk` in, 1: the single clock.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: begin a load; sampled in IDLE only.
- `abort` in, 1: cancel the load in progress.
- `word_data` in, WORD_W: bitstream word; bit WORD_W-1 is shifted first.
- `word_valid` in, 1: `word_data` is valid.
- `word_ready` out, 1: loader accepts `word_data` this cycle.
- `cfg_data_out` out, 1: to the chain head's `config_data_in`.
- `cfg_shift_en` out, 1: to the chain's `en`. The chain shifts on every edge where this is high.
- `cfg_mode` out, 1: to the chain's `config_en`. It forces fabric outputs to 0 while a load is in progress.
- `cfg_data_in` in, 1: from the chain tail's `config_data_out`.
- `rb_data` out, WORD_W: packed readback word.
- `rb_valid` out, 1: one-cycle pulse; `rb_data` is valid.
- `busy` out, 1: a load is in progress.
- `done` out, 1: one-cycle pulse when a load completes.

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.
- **IDLE**
  - All control outputs are low.
  - `start`=1 and `abort`=0 at an edge: go to FETCH and clear `bit_cnt`.
- **FETCH**
  - `word_ready`=1, `cfg_mode`=1, `busy`=1.
  - On `word_valid`&&`word_ready`: load the word into the shift register and set `word_bits` to min(WORD_W, CHAIN_LEN - `bit_cnt`). Go to SHIFT.
  - If `word_valid` is low, stay in FETCH with `cfg_shift_en` low. This stalls the load without losing bits.
- **SHIFT**
  - `cfg_shift_en`=1 and `cfg_data_out`=shreg[WORD_W-1] on every cycle.
  - At each edge:
    - shreg shifts left;
    - `bit_cnt` increments;
    - the readback register shifts in `cfg_data_in`, sampled at that edge, i.e. the pre-shift chain MSB.
  - After `word_bits` shifts: go to DONE if `bit_cnt`==CHAIN_LEN, otherwise go to FETCH.
- **Partial last word**
  - Applies when CHAIN_LEN is not a multiple of WORD_W.
  - Only the upper CHAIN_LEN mod WORD_W bits of the last word are shifted; its lower bits are ignored.
- **DONE**
  - `done`=1, `cfg_mode`=0, `busy`=0 for one cycle, then go to IDLE.
- **Readback**
  - After each word's final shift, the next cycle shows `rb_valid`=1 with `rb_data` holding the captured bits MSB-first.
  - A partial word is left-aligned and zero-filled.
  - `rb_data` holds its value until the next pulse.
- **Abort**
  - `abort`=1 in FETCH or SHIFT: go to IDLE at the next edge.
  - No `done` pulse and no `rb_valid` pulse for the incomplete word.
  - The chain is left partially shifted.
  - `abort` in IDLE or DONE is ignored.
  - `start` and `abort` high together in IDLE: stay in IDLE.
- `start` outside IDLE is ignored.
- **Reset** (`rst`, asynchronous): every output goes to 0 immediately, without a clock.
  - `rb_data`=0, `word_ready`=0, `cfg_shift_en`=0, `cfg_mode`=0, `cfg_data_out`=0, `rb_valid`=0, `busy`=0, `done`=0.
  - FSM returns to IDLE; `bit_cnt`=0.

## Timing
- Each word costs 1 accept cycle plus `word_bits` shift cycles.
- With `word_valid` held high, `done` is high in the cycle following edge E0 + N_WORDS*(WORD_W+1), where E0 is the edge that samples `start`. Adjust for a partial last word.
- Every stall cycle in FETCH delays `done` by exactly 1 cycle.
- `rb_valid` lags the final shift edge of its word by one edge.
- `cfg_data_out` is stable for the whole cycle in which `cfg_shift_en` is high. The chain samples it on the same edge.

## Structure
- Package `cfg_pkg` holds:
  - the state enum `cfg_state_t`;
  - the function `cfg_words(chain_len, word_w)`;
  - shared config-chain constants, including the switchbox bits-per-wire = 8.
- One sub-module, `cfg_rb_packer`, captures serial bits into WORD_W words with left-align and zero-fill on flush. The loader instantiates it once.

## Test plan
- **Full load, multiple-of-width chain.** Model the chain as a left-shifting register reset to all ones. CHAIN_LEN=8, WORD_W=4, words 0xA then 0x5, `word_valid` always high. Required response:
  - chain ends as 0xA5;
  - rb words 0xF, 0xF;
  - `done` high 10 edges after E0;
  - `cfg_mode` is high throughout FETCH/SHIFT and low in DONE.
- **Partial last word.** CHAIN_LEN=6, WORD_W=4, words 0xB then 0x8, chain initially 0x15. Required response:
  - chain ends as 0b101110 (0x2E);
  - only 6 `cfg_shift_en` cycles;
  - rb words 0x5, 0x4 (left-aligned "01").
- **Stall.** Same as the first test, but drop `word_valid` for 5 cycles before the second word. Required response: `cfg_shift_en` stays low during the gap, the chain still ends as 0xA5, and `done` arrives 5 cycles later.
- **Abort then restart.** Assert `abort` after 3 shift edges of the first word. Required response:
  - next cycle shows `busy`=0, `cfg_mode`=0;
  - no `done`, no `rb_valid`;
  - a new `start` reloads from bit 0, and the chain ends correct.
- **Async reset mid-SHIFT.** Assert `rst` between edges during SHIFT. Required response: all outputs read 0 before the next edge, and after release the block is in IDLE.
- **Ignored and conflicting start.**
  - `start` during SHIFT: no effect on the cycle count.
  - `start` and `abort` together in IDLE: `busy` stays 0.
